// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: IDLE -> ACCESS -> ACK transaction per grant.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt_id,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              mem_r,
  output logic              mem_w,
  output logic              mem_oe
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t            state, state_next;
  logic              grant_port;
  logic              start;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              gnt_q;
  logic [DATA_W-1:0] rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Port granted most recently; resets to 1 so port 0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_q <= 1'b1;
    else if (start)
      last_q <= grant_port;
  end
`endif

  always_comb begin
    grant_port = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_port = ~last_q;
`else
      grant_port = 1'b0;
`endif
    end else if (req1) begin
      grant_port = 1'b1;
    end
  end

  assign start = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Strobes decode from the state register so an async reset drops them at once.
  always_comb begin
    state_next = state;
    mem_ce     = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_oe     = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = ACCESS;
      end
      ACCESS: begin
        mem_ce     = 1'b1;
        mem_w      = we_lat;
        mem_r      = ~we_lat;
        mem_oe     = ~we_lat;
        state_next = ACK;
      end
      ACK: begin
        ack0       = ~gnt_q;
        ack1       = gnt_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only at the grant, isolating the transaction from later input changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      gnt_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (start) begin
        gnt_q     <= grant_port;
        we_lat    <= grant_port ? we1 : we0;
        addr_lat  <= grant_port ? addr1 : addr0;
        wdata_lat <= grant_port ? wdata1 : wdata0;
      end
      if (state == ACCESS && !we_lat)
        rdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = addr_lat;
  assign mem_wdata = wdata_lat;
  assign rdata     = rdata_q;
  assign gnt_id    = gnt_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single memory bus (RAM + memory-mapped IO window) between the CPU and a second bus master, the program loader or DMA. It sits between the requesters and the memory block. It sequences each access as a fixed three-state transaction, drives the memory's `ce`/`r`/`w`/`oe` strobes, and returns registered read data with a one-cycle acknowledge.

## Interface
- `ADDR_W`, 16: address width, same as the memory address bus.
- `DATA_W`, 8: data width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1 each  access request, port 0 (CPU) and port 1 (loader).
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W each  access address.
- `wdata0`, `wdata1`  in  DATA_W each  write data.
- `ack0`, `ack1`  out  1 each  one-cycle completion pulse.
- `rdata`  out  DATA_W  registered read data; valid while the matching ack is high.
- `gnt_id`  out  1  port that owns the current or most recent transaction.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, combinational from the memory.
- `mem_ce`, `mem_r`, `mem_w`, `mem_oe`  out  1 each  memory strobes.

## Operation
- FSM states:
  - IDLE: sample the requests.
  - ACCESS: drive the memory.
  - ACK: pulse the acknowledge.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port, latch its `we`, `addr` and `wdata` into internal registers, set `gnt_id`, go to ACCESS.
  - Both requests: arbitrate (see Configuration), then proceed as above.
- ACCESS, from the latched registers:
  - `mem_ce`=1, `mem_addr`=latched address, `mem_wdata`=latched data.
  - Write: `mem_w`=1, `mem_r`=0, `mem_oe`=0. The memory commits the write on the edge that leaves ACCESS.
  - Read: `mem_r`=1, `mem_oe`=1, `mem_w`=0. `rdata` captures `mem_rdata` on the edge that leaves ACCESS.
  - Always proceed to ACK.
- ACK:
  - Memory strobes all 0.
  - `ack[gnt_id]`=1 for exactly this cycle; the other ack stays 0.
  - Go to IDLE.
- Memory strobes are 0 in every state except ACCESS. The arbiter never asserts `mem_ce` for two consecutive cycles.
- Request fields are sampled only in IDLE. Changes to `addr`/`wdata`/`we` after the grant have no effect on the transaction in flight.
- A request held high through its ack cycle is a new request. It is sampled in the following IDLE cycle.
- A request dropped before it is granted is discarded; no ack is issued.
- `rdata` holds its value until the next read completes. Writes do not modify `rdata`.
- The memory's clear input is tied low at the top level; the arbiter never clears memory.

## Timing
- Reset asserted (async):
  - State = IDLE.
  - `ack0`=`ack1`=0, `rdata`=0, `gnt_id`=0.
  - `mem_ce`=`mem_r`=`mem_w`=`mem_oe`=0, `mem_addr`=0, `mem_wdata`=0.
  - Round-robin pointer = 1, so port 0 wins the first tie.
- Reset during ACCESS: the strobes drop immediately, no write commits, no ack is issued.
- Latency, with the request seen high at edge N while in IDLE:
  - ACCESS during cycle N+1.
  - Ack high during cycle N+2.
  - IDLE in cycle N+3.
- Throughput: one transaction per 3 cycles when a port holds `req` continuously.
- The second port waits at most one full transaction, 3 cycles, after the first port's grant.

## Configuration
- Macro `MEM_ARB_ROUND_ROBIN_EN`.
- Defined: on a tie, the arbiter grants the port not granted most recently.
  - The pointer updates on every grant.
  - Continuous requests from both ports alternate 0,1,0,1.
- Undefined: fixed priority, port 0 always wins a tie.
  - Port 1 is served only in IDLE cycles where `req0`=0.
  - The pointer logic is not synthesized.

## Test plan
- Single write: port 0 writes `addr`=0x0010, `wdata`=0xA5 → `mem_ce`=`mem_w`=1 for exactly one cycle with `mem_addr`=0x0010; `ack0` high 2 cycles after the request edge; a later read of 0x0010 returns `rdata`=0xA5.
- IO read: port 1 reads 0x0800 after a write of 0x3C → `mem_r`=`mem_oe`=1 for one cycle; `ack1` pulses with `rdata`=0x3C; `ack0` stays 0.
- Tie, macro defined: both ports request continuously → acks in order `ack0`, `ack1`, `ack0`, `ack1`, spaced 3 cycles apart.
- Tie, macro undefined: both ports request continuously for 12 cycles → only `ack0` pulses (4 times); dropping `req0` → `ack1` within 3 cycles.
- Field change after grant: change `addr0` from 0x0004 to 0x0005 during ACCESS → `mem_addr` stays 0x0004; the location at 0x0005 is unchanged.
- Reset mid-access: assert `rst`=0 during a write's ACCESS cycle → `mem_ce`/`mem_w` drop in the same cycle, the target location keeps its old value, no ack, all outputs at reset values.
